// File: rtl/imm_extend_buf.sv
// Immediate extension stage with a 2-entry output FIFO.
// Results are computed at input acceptance and held in order until the consumer takes them.
module imm_extend_buf #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32   // must be at least IN_W+2 so BOFS keeps a full shifted field
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [1:0]       mode_o
);

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_BOFS  = 2'b11;

    // Handshake: a transfer happens on a rising clk_i edge where valid and ready
    // are both high; valid never depends on ready, and ready_o comes only from
    // registered count, so there is no combinational path from ready_i to ready_o.

    logic [OUT_W-1:0] entry_data [0:1];
    logic [1:0]       entry_mode [0:1];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;

    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] upper_val;
    logic [OUT_W-1:0] bofs_val;
    logic [OUT_W-1:0] ext_val;

    assign sext_val  = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};
    assign zext_val  = {{(OUT_W-IN_W){1'b0}}, data_i};
    assign upper_val = {data_i, {(OUT_W-IN_W){1'b0}}};
    assign bofs_val  = {sext_val[OUT_W-3:0], 2'b00};

    always_comb begin
        ext_val = sext_val;
        case (mode_i)
            MODE_SEXT:  ext_val = sext_val;
            MODE_ZEXT:  ext_val = zext_val;
            MODE_UPPER: ext_val = upper_val;
            MODE_BOFS:  ext_val = bofs_val;
            default:    ext_val = sext_val;
        endcase
    end

    assign ready_o = (count < 2'd2);
    assign valid_o = (count != 2'd0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // Head is gated to zero when empty, so entry storage needs no reset.
    assign data_o = valid_o ? entry_data[rd_ptr] : '0;
    assign mode_o = valid_o ? entry_mode[rd_ptr] : 2'b00;

    always_ff @(posedge clk_i) begin
        if (push) begin
            entry_data[wr_ptr] <= ext_val;
            entry_mode[wr_ptr] <= mode_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_buf.sv
// Self-checking bench for imm_extend_buf: queue-based reference model checked every
// cycle, plus directed literal checks for each mode, backpressure, streaming and reset.
module tb_imm_extend_buf;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic             clk_i;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [IN_W-1:0]  data_i;
    logic [1:0]       mode_i;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] data_o;
    logic [1:0]       mode_o;

    int checks = 0;
    int errors = 0;

    // each queue entry is {mode, result}
    logic [OUT_W+1:0] exp_q[$];

    imm_extend_buf #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .mode_o  (mode_o)
    );

    // clock / reset block
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // reference extension computed arithmetically
    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] d, input logic [1:0] m);
        logic signed [OUT_W-1:0] s;
        s = $signed(d);
        case (m)
            2'd0:    return s;
            2'd1:    return OUT_W'(d);
            2'd2:    return OUT_W'(d) << (OUT_W - IN_W);
            default: return s * 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // model update on the active edge, from the inputs sampled at that edge
    always @(posedge clk_i) begin
        if (rst_i) begin
            bit do_push, do_pop;
            do_push = valid_i && (exp_q.size() < 2);
            do_pop  = ready_i && (exp_q.size() != 0);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({mode_i, ext(data_i, mode_i)});
        end
    end

    always @(negedge rst_i) exp_q.delete();

    // per-cycle compare against the model
    always @(negedge clk_i) begin
        logic [OUT_W+1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("cyc_valid", 64'(valid_o), 64'(exp_q.size() != 0));
        check("cyc_ready", 64'(ready_o), 64'(exp_q.size() < 2));
        check("cyc_data",  64'(data_o),  64'(head[OUT_W-1:0]));
        check("cyc_mode",  64'(mode_o),  64'(head[OUT_W+1:OUT_W]));
    end

    // driver tasks: inputs change 2 time units after the rising edge
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push_check(input logic [IN_W-1:0] d, input logic [1:0] m,
                              input logic [OUT_W-1:0] lit, input string name);
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        mode_i  = m;
        step();
        valid_i = 1'b0;
        @(negedge clk_i);
        check({name, "_valid"}, 64'(valid_o), 64'd1);
        check({name, "_data"},  64'(data_o),  64'(lit));
        check({name, "_mode"},  64'(mode_o),  64'(m));
        step();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    initial begin
        logic [IN_W-1:0] a, b, c;
        int budget;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        mode_i  = 2'b00;
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_data",  64'(data_o),  64'd0);
        check("rst_mode",  64'(mode_o),  64'd0);

        // pin the model against hand-computed values
        check("model_sext",  64'(ext(16'h8001, 2'd0)), 64'h0000_0000_FFFF_8001);
        check("model_bofs",  64'(ext(16'h4000, 2'd3)), 64'h0000_0000_0001_0000);

        step();
        step();
        rst_i = 1'b1;
        step();

        push_check(16'h8001, 2'b00, 32'hFFFF8001, "sext");
        push_check(16'h8001, 2'b01, 32'h00008001, "zext");
        push_check(16'h1234, 2'b10, 32'h12340000, "upper");
        push_check(16'hFFFF, 2'b11, 32'hFFFFFFFC, "bofs_neg");
        push_check(16'h4000, 2'b11, 32'h00010000, "bofs_pos");

        // backpressure: fill, attempt a third push, then drain in order
        a = 16'hA5A5; b = 16'h0F0F; c = 16'h7777;
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = a; mode_i = 2'b10;
        step();
        data_i = b; mode_i = 2'b11;
        step();
        data_i = c; mode_i = 2'b01;
        @(negedge clk_i);
        check("bp_full_ready", 64'(ready_o), 64'd0);
        step();
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_first_data", 64'(data_o), 64'(32'hA5A50000));
        check("bp_first_mode", 64'(mode_o), 64'd2);
        step();
        @(negedge clk_i);
        check("bp_second_data", 64'(data_o), 64'(32'h00003C3C));
        check("bp_second_mode", 64'(mode_o), 64'd3);
        step();
        @(negedge clk_i);
        check("bp_empty", 64'(valid_o), 64'd0);

        // streaming: one accepted and one delivered per cycle
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid_i = 1'b1;
            data_i  = IN_W'($urandom);
            mode_i  = 2'($urandom_range(0, 3));
            step();
            check("stream_ready", 64'(ready_o), 64'd1);
        end
        valid_i = 1'b0;
        step();

        // simultaneous push and pop at count 1
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = 16'h0042; mode_i = 2'b01;
        step();
        data_i = 16'hFF00; mode_i = 2'b00; ready_i = 1'b1;
        step();
        valid_i = 1'b0; ready_i = 1'b0;
        @(negedge clk_i);
        check("sim_valid", 64'(valid_o), 64'd1);
        check("sim_ready", 64'(ready_o), 64'd1);
        check("sim_data",  64'(data_o),  64'(32'hFFFFFF00));
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;

        // random traffic
        for (int i = 0; i < 300; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            data_i  = IN_W'($urandom);
            mode_i  = 2'($urandom_range(0, 3));
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        budget = 10;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);

        // async reset with FIFO full, asserted between edges
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = 16'h1111; mode_i = 2'b10;
        step();
        data_i = 16'h2222;
        step();
        valid_i = 1'b0;
        @(negedge clk_i);
        check("ar_full", 64'(ready_o), 64'd0);
        #1 rst_i = 1'b0;
        #1;
        check("ar_valid", 64'(valid_o), 64'd0);
        check("ar_data",  64'(data_o),  64'd0);
        check("ar_mode",  64'(mode_o),  64'd0);
        check("ar_ready", 64'(ready_o), 64'd1);
        step();
        rst_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_no_reappear", 64'(valid_o), 64'd0);
        end
        ready_i = 1'b0;
        push_check(16'h00FF, 2'b00, 32'h000000FF, "post_rst");

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_buf.md
IMM_EXTEND_BUF -- requirements
Module: imm_extend_buf

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate field width.
REQ-002 SHALL have parameter OUT_W, default 32, extended result width; legal only when OUT_W >= IN_W+2.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  upstream immediate valid.
REQ-006 SHALL have port ready_o  output  1  block can accept an input this cycle.
REQ-007 SHALL have port data_i  input  IN_W  raw immediate field.
REQ-008 SHALL have port mode_i  input  2  extension mode, sampled with data_i.
REQ-009 SHALL have port valid_o  output  1  head result valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts result.
REQ-011 SHALL have port data_o  output  OUT_W  extended result at buffer head.
REQ-012 SHALL have port mode_o  output  2  mode tag travelling with the head result.

Function
REQ-013 SHALL perform input transfer on a rising edge where valid_i=1 and ready_o=1; output transfer where valid_o=1 and ready_i=1.
REQ-014 SHALL compute the result at input transfer, per mode_i:
- 00 SEXT: data_i[IN_W-1] replicated into bits OUT_W-1..IN_W, data_i in low bits.
- 01 ZEXT: zeros in bits OUT_W-1..IN_W.
- 10 UPPER: data_i placed in bits OUT_W-1..OUT_W-IN_W, zeros below.
- 11 BOFS: SEXT result shifted left 2, bits shifted past OUT_W-1 discarded, bits 1..0 zero.
REQ-015 SHALL store results in a 2-entry FIFO (entries, read pointer, write pointer, 2-bit count); pointers wrap 1->0.
REQ-016 SHALL drive ready_o = (count < 2), purely from registered count; no combinational path from ready_i to ready_o.
REQ-017 SHALL drive valid_o = (count != 0), data_o/mode_o from the head entry; data_o = 0 and mode_o = 00 when count = 0.
REQ-018 SHALL have latency exactly 1 cycle: input accepted at edge N appears on valid_o/data_o after edge N when FIFO was empty.
REQ-019 SHALL, on simultaneous input and output transfer, keep count unchanged, advance both pointers, preserve order.
REQ-020 SHALL ignore data_i/mode_i when valid_i=0 or ready_o=0; no state change.
REQ-021 SHALL hold data_o, mode_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL deliver results strictly in acceptance order; no drop, no duplication.
REQ-023 SHALL, when count = 2, refuse input; an output transfer that edge makes ready_o=1 the following cycle only.
REQ-024 SHALL treat X-free mode_i as exhaustive; no undefined mode.

Reset
REQ-025 SHALL, while rst_i=0, immediately force count=0, both pointers=0, valid_o=0, data_o=0, mode_o=00, ready_o=1.
REQ-026 SHALL discard any buffered results on reset asserted mid-operation; no output transfer occurs after deassertion until a new input is accepted.
REQ-027 SHALL not require entry storage to be cleared; only head output gating to zero is mandatory.

Verification
REQ-028 SHALL verify SEXT/ZEXT: default params, data_i=16'h8001 mode 00 -> data_o=32'hFFFF8001; same with mode 01 -> 32'h00008001, each one cycle after acceptance.
REQ-029 SHALL verify UPPER/BOFS: data_i=16'h1234 mode 10 -> 32'h12340000; data_i=16'hFFFF mode 11 -> 32'hFFFFFFFC; data_i=16'h4000 mode 11 -> 32'h00010000.
REQ-030 SHALL verify backpressure: ready_i=0, push A, B -> ready_o=0 after second push, third valid_i ignored; release ready_i -> A then B out in order, mode_o tags match.
REQ-031 SHALL verify streaming: ready_i=1, valid_i=1 every cycle for 20 random inputs -> one result per cycle, count never exceeds 1, all results match golden model.
REQ-032 SHALL verify simultaneous push/pop at count=1 -> count stays 1, output order preserved.
REQ-033 SHALL verify async reset: FIFO full, drop rst_i between edges -> valid_o=0, data_o=0, ready_o=1 immediately without clock edge; previous entries never reappear.
